// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_display_ctrl                                            |
// | Description : Hex 7-segment controller with registered decode, leading-    |
// |               zero blanking, per-digit blink and optional digit scan.      |
// |               Scan multiplexer built when SEG7_DISPLAY_CTRL_SCAN_EN is set. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_display_ctrl #(
   parameter int DIGITS    = 6,
   parameter int BLINK_DIV = 25000000,
   parameter int SCAN_DIV  = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [4*DIGITS-1:0]   wdata,
   input  logic                  lzb,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [7*DIGITS-1:0]   seg_out,
   output logic                  ack,
   output logic [6:0]            seg_scan,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam logic [6:0] C_SEG_BLANK = 7'h7F;
   localparam int         C_BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [C_BW-1:0] C_BLINK_LAST = C_BW'(BLINK_DIV - 1);

   if (DIGITS < 1 || DIGITS > 8 || BLINK_DIV < 2 || SCAN_DIV < 1) begin : g_param_check
      $error("seg7_display_ctrl: illegal parameter value");
   end

   // Active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex2seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1011000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [4*DIGITS-1:0] value_q;
   logic                wr_pend_q;
   logic [7*DIGITS-1:0] seg_q;
   logic [7*DIGITS-1:0] seg_d;
   logic                ack_q;
   logic [C_BW-1:0]     blink_cnt_q;
   logic                blink_phase_q;
   logic                zero_run;
   logic                blank;

   // Walk from the top digit down so zero_run means "this nibble and all above are zero"
   always_comb begin
      seg_d    = '1;
      zero_run = 1'b1;
      blank    = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (value_q[4*i +: 4] == 4'h0);
         blank    = ((i != 0) && lzb && zero_run) || (blink_phase_q && blink_mask[i]);
         seg_d[7*i +: 7] = blank ? C_SEG_BLANK : hex2seg(value_q[4*i +: 4]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q       <= '0;
         wr_pend_q     <= 1'b0;
         seg_q         <= '1;
         ack_q         <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         if (we) begin
            value_q <= wdata;
         end
         wr_pend_q <= we;
         seg_q     <= seg_d;
         ack_q     <= wr_pend_q;
         if (blink_cnt_q == C_BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   assign seg_out = seg_q;
   assign ack     = ack_q;

`ifdef SEG7_DISPLAY_CTRL_SCAN_EN
   localparam int C_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int C_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [C_IW-1:0] C_IDX_LAST  = C_IW'(DIGITS - 1);
   localparam logic [C_SW-1:0] C_SCAN_LAST = C_SW'(SCAN_DIV - 1);

   logic [C_SW-1:0]     scan_cnt_q;
   logic [C_IW-1:0]     idx_q;
   logic [DIGITS-1:0]   dig_sel_q;
   logic [DIGITS-1:0]   dig_sel_d;
   logic [6:0]          seg_scan_q;
   logic [6:0]          seg_scan_d;
   logic [7*DIGITS-1:0] seg_shift;

   always_comb begin
      dig_sel_d  = DIGITS'(1) << idx_q;
      seg_shift  = seg_q >> (32'(idx_q) * 7);
      seg_scan_d = seg_shift[6:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         dig_sel_q  <= '0;
         seg_scan_q <= C_SEG_BLANK;
      end else begin
         if (scan_cnt_q == C_SCAN_LAST) begin
            scan_cnt_q <= '0;
            idx_q      <= (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
         end
         dig_sel_q  <= dig_sel_d;
         seg_scan_q <= seg_scan_d;
      end
   end

   assign dig_sel  = dig_sel_q;
   assign seg_scan = seg_scan_q;
`else
   assign dig_sel  = '0;
   assign seg_scan = C_SEG_BLANK;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_display_ctrl                                         |
// | Description : Directed, table-driven self-checking bench for the           |
// |               seg7_display_ctrl block (DIGITS=6, BLINK_DIV=4, SCAN_DIV=2). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_display_ctrl;

   localparam int DIGITS = 6;

   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h58;
   localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SA = 7'h08, SB = 7'h03;
   localparam logic [6:0] SC = 7'h46, SD = 7'h21, SE = 7'h06, SF = 7'h0E;
   localparam logic [6:0] BL = 7'h7F;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  we;
   logic [4*DIGITS-1:0]   wdata;
   logic                  lzb;
   logic [DIGITS-1:0]     blink_mask;
   logic [7*DIGITS-1:0]   seg_out;
   logic                  ack;
   logic [6:0]            seg_scan;
   logic [DIGITS-1:0]     dig_sel;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [23:0] data;
      logic        lzb;
      logic [41:0] exp_seg;
   } vec_t;

   vec_t vecs [10];

   logic [6:0] blink_s [24];
   logic [5:0] ds_s    [30];
   logic [6:0] ss_s    [30];

   seg7_display_ctrl #(
      .DIGITS    (DIGITS),
      .BLINK_DIV (4),
      .SCAN_DIV  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .wdata      (wdata),
      .lzb        (lzb),
      .blink_mask (blink_mask),
      .seg_out    (seg_out),
      .ack        (ack),
      .seg_scan   (seg_scan),
      .dig_sel    (dig_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int k;
      logic [6:0] other;
      logic [6:0] exp_d0;
      logic [6:0] scan_codes [6];

      vecs[0] = '{24'h0012AF, 1'b0, {S0, S0, S1, S2, SA, SF}};
      vecs[1] = '{24'h0012AF, 1'b1, {BL, BL, S1, S2, SA, SF}};
      vecs[2] = '{24'h000000, 1'b1, {BL, BL, BL, BL, BL, S0}};
      vecs[3] = '{24'h000000, 1'b0, {S0, S0, S0, S0, S0, S0}};
      vecs[4] = '{24'h345678, 1'b0, {S3, S4, S5, S6, S7, S8}};
      vecs[5] = '{24'h9ABCDE, 1'b1, {S9, SA, SB, SC, SD, SE}};
      vecs[6] = '{24'h100000, 1'b1, {S1, S0, S0, S0, S0, S0}};
      vecs[7] = '{24'h000F00, 1'b1, {BL, BL, BL, SF, S0, S0}};
      vecs[8] = '{24'h000001, 1'b1, {BL, BL, BL, BL, BL, S1}};
      vecs[9] = '{24'hF0F0F0, 1'b1, {SF, S0, SF, S0, SF, S0}};

      reset = 1'b1; we = 1'b0; wdata = '0; lzb = 1'b0; blink_mask = '0;

      // Reset state
      #12;
      check("reset_seg_out",  64'(seg_out),  64'h3FF_FFFF_FFFF);
      check("reset_ack",      64'(ack),      64'h0);
      check("reset_dig_sel",  64'(dig_sel),  64'h0);
      check("reset_seg_scan", 64'(seg_scan), 64'(BL));
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("post_reset_seg", 64'(seg_out), 64'({S0, S0, S0, S0, S0, S0}));
      check("post_reset_ack", 64'(ack), 64'h0);

      // Table-driven single writes
      foreach (vecs[v]) begin
         @(negedge clk);
         we = 1'b1; wdata = vecs[v].data; lzb = vecs[v].lzb;
         @(negedge clk);
         we = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_seg", v), 64'(seg_out), 64'(vecs[v].exp_seg));
         check($sformatf("vec%0d_ack", v), 64'(ack), 64'h1);
         @(negedge clk);
         check($sformatf("vec%0d_ack_end", v), 64'(ack), 64'h0);
      end

      // Back-to-back writes: two acks, last value wins
      @(negedge clk);
      lzb = 1'b0; we = 1'b1; wdata = 24'h000A5C;
      @(negedge clk);
      wdata = 24'h00B3E1;
      @(negedge clk);
      we = 1'b0;
      check("b2b_seg_first", 64'(seg_out), 64'({S0, S0, S0, SA, S5, SC}));
      check("b2b_ack_first", 64'(ack), 64'h1);
      @(negedge clk);
      check("b2b_seg_second", 64'(seg_out), 64'({S0, S0, SB, S3, SE, S1}));
      check("b2b_ack_second", 64'(ack), 64'h1);
      @(negedge clk);
      check("b2b_ack_end", 64'(ack), 64'h0);

      // lzb level change reaches display one edge later with no ack
      lzb = 1'b1;
      @(negedge clk);
      check("lzb_level_seg", 64'(seg_out), 64'({BL, BL, SB, S3, SE, S1}));
      check("lzb_level_ack", 64'(ack), 64'h0);

      // Blink: digit 0 toggles every 4 cycles, others untouched
      lzb = 1'b0; we = 1'b1; wdata = 24'h000008;
      @(negedge clk);
      we = 1'b0;
      @(negedge clk);
      blink_mask = 6'b000001;
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < 24; j++) begin
         @(negedge clk);
         blink_s[j] = seg_out[6:0];
         check("blink_others", 64'(seg_out[41:7]), 64'({S0, S0, S0, S0, S0}));
      end
      k = 0;
      for (int j = 4; j >= 1; j--) begin
         if (blink_s[j] !== blink_s[j-1]) k = j;
      end
      if (k == 0) begin
         n_tests++; n_fail++;
         $display("FAIL blink_toggle: digit0 constant %0h, expected alternating", blink_s[0]);
      end else begin
         check("blink_level", 64'((blink_s[k] === S8) || (blink_s[k] === BL)), 64'h1);
         other = (blink_s[k] === S8) ? BL : S8;
         for (int j = k + 1; j < k + 16; j++) begin
            exp_d0 = ((((j - k) / 4) % 2) == 0) ? blink_s[k] : other;
            check($sformatf("blink_d0_%0d", j), 64'(blink_s[j]), 64'(exp_d0));
         end
      end
      blink_mask = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset pulse between capture and display suppresses update and ack
      we = 1'b1; wdata = 24'h123456;
      @(posedge clk);
      #1 we = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("midreset_seg", 64'(seg_out), 64'h3FF_FFFF_FFFF);
      check("midreset_ack", 64'(ack), 64'h0);
      #1 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midreset_seg_after", 64'(seg_out), 64'({S0, S0, S0, S0, S0, S0}));
      check("midreset_no_ack", 64'(ack), 64'h0);
      @(negedge clk);
      check("midreset_no_ack2", 64'(ack), 64'h0);

      // Write coincident with reset is discarded
      reset = 1'b1; we = 1'b1; wdata = 24'hFFFFFF;
      @(negedge clk);
      check("wr_in_reset_seg", 64'(seg_out), 64'h3FF_FFFF_FFFF);
      reset = 1'b0; we = 1'b0;
      @(negedge clk);
      check("wr_in_reset_ack", 64'(ack), 64'h0);
      @(negedge clk);
      check("wr_in_reset_val", 64'(seg_out), 64'({S0, S0, S0, S0, S0, S0}));
      check("wr_in_reset_ack2", 64'(ack), 64'h0);

      // Scan path
      we = 1'b1; wdata = 24'h001A78; lzb = 1'b0;
      @(negedge clk);
      we = 1'b0;
      repeat (4) @(negedge clk);
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         ds_s[j] = dig_sel;
         ss_s[j] = seg_scan;
      end
`ifdef SEG7_DISPLAY_CTRL_SCAN_EN
      scan_codes[0] = S8; scan_codes[1] = S7; scan_codes[2] = SA;
      scan_codes[3] = S1; scan_codes[4] = S0; scan_codes[5] = S0;
      k = 0;
      for (int j = 13; j >= 1; j--) begin
         if (ds_s[j] === 6'b000001 && ds_s[j-1] !== 6'b000001) k = j;
      end
      if (k == 0) begin
         n_tests++; n_fail++;
         $display("FAIL scan_start: dig_sel %0h, expected rotation through 000001", ds_s[0]);
      end else begin
         for (int j = 0; j < 14; j++) begin
            check($sformatf("scan_sel_%0d", j), 64'(ds_s[k+j]), 64'(6'b000001 << ((j / 2) % 6)));
            check($sformatf("scan_seg_%0d", j), 64'(ss_s[k+j]), 64'(scan_codes[(j / 2) % 6]));
         end
      end
`else
      scan_codes[0] = BL;
      for (int j = 0; j < 30; j += 5) begin
         check($sformatf("noscan_sel_%0d", j), 64'(ds_s[j]), 64'h0);
         check($sformatf("noscan_seg_%0d", j), 64'(ss_s[j]), 64'(scan_codes[0]));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
